// File: rtl/datapath_pkg.sv
// Shared datapath definitions: opcode and ALU constants, responder state
// encoding, and the access-legality rule used by the data memory responder.
package datapath_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SW   = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b000100;
  localparam logic [3:0] ALU_ADD = 4'b0101;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } resp_state_e;

  // An access is illegal if it is both a load and a store, is not word
  // aligned, or addresses a word beyond the end of the array.
  function automatic logic access_err(input logic        rd,
                                      input logic        wr,
                                      input logic [31:0] addr,
                                      input int unsigned depth);
    return (rd & wr) | (addr[1:0] != 2'b00) | ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the datapath and the data memory responder.
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic        busy;

  modport master (
    output req_valid, MemRead, MemWrite, addr, wdata,
    input  req_ready, resp_valid, resp_err, rdata, busy
  );

  modport slave (
    input  req_valid, MemRead, MemWrite, addr, wdata,
    output req_ready, resp_valid, resp_err, rdata, busy
  );

endinterface

// File: rtl/data_mem_responder_dm_array.sv
// DEPTH x 32 word storage: synchronous write port, combinational read port.
module dm_array #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: storage is deliberately left out of reset; clearing a whole array
  // costs a reset net on every bit and nothing here depends on its contents.
  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder for lw/sw: accepts one word access per
// handshake and returns a one-cycle response carrying read data or an error.
module data_mem_responder
  import datapath_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic              req_err;
  logic              complete;
  logic              mem_we;
  logic              cur_wr;
  logic [IDX_W-1:0]  cur_idx;
  logic [31:0]       cur_wdata;
  logic [31:0]       arr_rdata;

  assign accept  = bus.req_valid & (state_q == IDLE) & (bus.MemRead | bus.MemWrite);
  assign req_err = access_err(bus.MemRead, bus.MemWrite, bus.addr, DEPTH);

  // With zero wait states the access completes on the accept edge, so the
  // array sees live inputs in IDLE and the captured request otherwise.
  always_comb begin
    cur_wr    = wr_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_wr    = bus.MemWrite;
      cur_idx   = bus.addr[IDX_W+1:2];
      cur_wdata = bus.wdata;
    end
  end

  // NOTE: every signal gets its hold value first so no path through the
  // case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    resp_err_d = resp_err_q;
    rdata_d    = rdata_q;
    complete   = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = bus.MemWrite;
          idx_d   = bus.addr[IDX_W+1:2];
          wdata_d = bus.wdata;
          if (req_err) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
            rdata_d    = '0;
          end else if (WAIT_CYCLES == 0) begin
            state_d  = RESP;
            complete = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (complete) begin
      resp_err_d = 1'b0;
      mem_we     = cur_wr;
      if (!cur_wr) rdata_d = arr_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_err_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      resp_err_q <= resp_err_d;
      rdata_q    <= rdata_d;
    end
  end

  dm_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .widx  (cur_idx),
    .wdata (cur_wdata),
    .ridx  (cur_idx),
    .rdata (arr_rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = resp_err_q;
  assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, random traffic against
// a word-array model, reset abort, and a zero-wait-state instance.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int W     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  int n_checks = 0;
  int n_errors = 0;
  int last_wait;

  logic [31:0] model_mem   [DEPTH];
  bit          model_known [DEPTH];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          scramble;
    bit          exp_err;
    logic [31:0] exp_rdata;
    bit          chk_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic bit model_err(input logic rd, input logic wr, input logic [31:0] a);
    return (rd && wr) || (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  // One access on the WAIT_CYCLES=2 instance: waits for ready, checks
  // latency, ready-low span, error flag and (optionally) read data.
  task automatic run_req(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input bit scramble,
                         input bit exp_err, input logic [31:0] exp_rdata, input bit chk_rdata);
    int lat;
    int low;
    int exp_lat;
    exp_lat = exp_err ? 1 : W + 1;
    bus.req_valid = 1'b1;
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.addr      = a;
    bus.wdata     = d;
    last_wait = 0;
    while (!bus.req_ready && last_wait < 40) begin
      @(posedge clk); #1;
      last_wait++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (scramble) begin
      bus.addr  = $urandom;
      bus.wdata = $urandom;
    end
    if (!model_err(rd, wr, a) && wr) begin
      model_mem[int'(a >> 2)]   = d;
      model_known[int'(a >> 2)] = 1'b1;
    end
    lat = 0;
    low = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!bus.req_ready) low++;
      if (bus.resp_valid) begin
        lat = c;
        break;
      end
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " ready_low"}, low, exp_lat);
    check({name, " resp_err"}, 32'(bus.resp_err), 32'(exp_err));
    if (chk_rdata) check({name, " rdata"}, bus.rdata, exp_rdata);
  endtask

  // One access on the zero-wait-state instance: response must follow accept.
  task automatic run0(input string name, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit exp_err, input logic [31:0] exp_rdata, input bit chk_rdata);
    bus0.req_valid = 1'b1;
    bus0.MemRead   = rd;
    bus0.MemWrite  = wr;
    bus0.addr      = a;
    bus0.wdata     = d;
    for (int c = 0; c < 40 && !bus0.req_ready; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    check({name, " resp_valid"}, 32'(bus0.resp_valid), 32'd1);
    check({name, " resp_err"}, 32'(bus0.resp_err), 32'(exp_err));
    if (chk_rdata) check({name, " rdata"}, bus0.rdata, exp_rdata);
    @(negedge clk);
    check({name, " valid/ready after"}, 32'({bus0.resp_valid, bus0.req_ready}), 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h12,       32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h100,      32'h11111111, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h10,       32'h22222222, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'hFC,       32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'hFC,       32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h80000010, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h14,       32'h0BADF00D, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h14,       32'h0,        1'b1, 1'b0, 32'h0BADF00D, 1'b1};

    bus.req_valid  = 1'b0; bus.MemRead  = 1'b0; bus.MemWrite  = 1'b0; bus.addr  = '0; bus.wdata  = '0;
    bus0.req_valid = 1'b0; bus0.MemRead = 1'b0; bus0.MemWrite = 1'b0; bus0.addr = '0; bus0.wdata = '0;

    #12;
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_err", 32'(bus.resp_err), 32'd0);
    check("reset rdata", bus.rdata, 32'h0);
    check("reset busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].scramble, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].chk_rdata);
      if (i == 1) check("back-to-back ready wait", last_wait, 32'd1);
    end

    repeat (3) @(negedge clk);
    check("hold rdata", bus.rdata, 32'h0BADF00D);
    check("hold resp_err", 32'(bus.resp_err), 32'd0);
    check("hold resp_valid", 32'(bus.resp_valid), 32'd0);
    check("hold busy", 32'(bus.busy), 32'd0);

    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.addr      = 32'h10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("noop%0d ready/valid/busy", c),
            32'({bus.req_ready, bus.resp_valid, bus.busy}), 32'b100);
    end
    bus.req_valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int          kind;
      int          idx;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      bit          e;
      logic [31:0] er;
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, DEPTH - 1);
      a    = 32'(idx * 4);
      d    = $urandom;
      if (kind < 4 || !model_known[idx]) begin rd = 1'b0; wr = 1'b1; end
      else begin rd = 1'b1; wr = 1'b0; end
      if (kind == 7) begin rd = 1'b1; wr = 1'b1; end
      if (kind == 8) a = a | 32'($urandom_range(1, 3));
      if (kind == 9) a = 32'(DEPTH * 4 + idx * 4);
      e  = model_err(rd, wr, a);
      er = (e || wr) ? 32'h0 : model_mem[int'(a >> 2)];
      run_req($sformatf("rand%0d", i), rd, wr, a, d, 1'($urandom_range(0, 1)),
              e, er, e || (rd && !wr));
    end

    run_req("preload20", 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b1;
    bus.addr      = 32'h20;
    bus.wdata     = 32'h12345678;
    for (int c = 0; c < 40 && !bus.req_ready; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort busy before reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort req_ready", 32'(bus.req_ready), 32'd1);
    check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort resp_err", 32'(bus.resp_err), 32'd0);
    check("abort rdata", bus.rdata, 32'h0);
    check("abort busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("abort lw20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, model_mem[8], 1'b1);

    run0("w0 sw8", 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    run0("w0 lw8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);
    run0("w0 lw9", 1'b1, 1'b0, 32'h9, 32'h0, 1'b1, 32'h0, 1'b1);
    run0("w0 lw8 again", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the single-cycle datapath's MemRead/MemWrite control signals (lw/sw). The block accepts one word access per request handshake, models a wait-state data memory, and returns a response with read data or an error flag. It sits between the control unit and ALU outputs on one side and the register-file write-back mux on the other.

## Interface
- DEPTH, 64: number of 32-bit words; word index = addr[31:2].
- WAIT_CYCLES, 2: access wait states (0..15); 0 is legal.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- MemRead  in  1  read request qualifier (lw).
- MemWrite  in  1  write request qualifier (sw).
- addr  in  32  byte address from ALU result.
- wdata  in  32  store data.
- resp_valid  out  1  one-cycle response strobe.
- resp_err  out  1  response is an error; valid with resp_valid.
- rdata  out  32  read data; held until next response.
- busy  out  1  high in ACCESS or RESP.

## Operation
- Accept = req_valid & req_ready & (MemRead | MemWrite). When MemRead and MemWrite are both 0, the request is not accepted, no response is produced, and the block stays in IDLE.
- On accept, latch op, addr, and wdata. Later input changes have no effect.
- Error if any of the following holds: MemRead & MemWrite; addr[1:0] != 0; addr[31:2] >= DEPTH.
- FSM states IDLE, ACCESS, RESP:
  - IDLE -> RESP on accept with error.
  - IDLE -> ACCESS on accept with no error and WAIT_CYCLES > 0.
  - IDLE -> RESP on accept with no error and WAIT_CYCLES = 0.
  - ACCESS: wait counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0 the memory operation is performed and the FSM goes to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Write: array[index] <= wdata on the completing edge. Read: rdata <= array[index] on the same edge.
- Error response: resp_err = 1, rdata = 0, no array write.
- Non-error response: resp_err = 0.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_err 0, rdata 0, busy 0, counter 0. Array contents are not reset.
- Reset mid-operation aborts immediately. A pending write not yet committed is dropped. A write committed on an earlier edge persists.

## Timing
- Accept on edge N. With no error, resp_valid is high in cycle N+WAIT_CYCLES+1. With an error, resp_valid is high in cycle N+1.
- req_ready drops in the cycle after accept and rises in the cycle after RESP. Throughput is one request per WAIT_CYCLES+2 cycles, so back-to-back lw/sw is allowed with no idle gap.
- A read issued after a write to the same address returns the new data.
- rdata and resp_err are registered and stable from resp_valid until the next response.

## Structure
- Shared package `datapath_pkg`:
  - opcode constants OP_ADD = 6'b000001, OP_SW = 6'b000010, OP_LW = 6'b000100;
  - responder state encoding IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  - ALU_ADD = 4'b0101.
- One sub-module, `dm_array`: DEPTH x 32 array with synchronous write (we, widx, wdata) and combinational read (ridx, rdata). The FSM, counter, error check, and output registers live in data_mem_responder.

## Test plan
- Reset, then sw: addr = 0x10, wdata = 0xDEADBEEF, WAIT_CYCLES = 2. Required: resp_valid exactly 3 cycles after accept, resp_err = 0, req_ready low for 3 cycles.
- Back-to-back lw: addr = 0x10 accepted the cycle req_ready returns. Required: rdata = 0xDEADBEEF, resp_err = 0.
- Misaligned access: lw at addr = 0x12. Required: resp_valid 1 cycle after accept, resp_err = 1, rdata = 0. A follow-up lw at 0x10 still returns 0xDEADBEEF.
- Other errors, each expecting resp_err = 1 and no array change:
  - out-of-range sw at addr = 4*DEPTH = 0x100;
  - MemRead = MemWrite = 1 at addr = 0x10.
- No-op and input capture:
  - req_valid = 1 with MemRead = MemWrite = 0 for 5 cycles: no accept, no resp_valid, req_ready stays 1.
  - Change addr/wdata during ACCESS: no effect on the result.
- Reset abort and WAIT_CYCLES = 0:
  - Assert rst_n = 0 during ACCESS of a sw 0x20 = 0x12345678. After reset, lw 0x20 does not return 0x12345678 (preload 0 first), and all outputs hold reset values.
  - Separate build with WAIT_CYCLES = 0: resp_valid one cycle after accept.
